// File: rtl/clk_div_pkg.sv
// clk_div_pkg: lock FSM states and config clamp helpers shared by clk_div_mgr
package clk_div_pkg;
  typedef enum logic [1:0] {
    RST    = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;
  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction
  // high beyond div would only ever read as constant 1, so store it saturated at div
  function automatic int unsigned clamp_high(input int unsigned h, input int unsigned d);
    return (h > d) ? d : h;
  endfunction
  function automatic int unsigned clamp_phase(input int unsigned p, input int unsigned d);
    return (p >= d) ? 0 : p;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel; takes pending config at wrap or resync, registered outputs
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DW      = 8,
  parameter int DEF_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pend,
  input  logic          resync,
  input  logic [DW-1:0] new_div,
  input  logic [DW-1:0] new_high,
  input  logic [DW-1:0] new_phase,
  output logic          apply,
  output logic          clk_out,
  output logic          clk_en
);
  localparam logic [DW-1:0] RST_DIV  = DW'(clamp_div(DEF_DIV));
  localparam logic [DW-1:0] RST_HIGH = DW'(clamp_high(DEF_DIV / 2, clamp_div(DEF_DIV)));
  logic [DW-1:0] cnt, div_r, high_r, phase_r;
  logic [DW-1:0] nd, nh, np, div_n, high_n, phase_n, cnt_n;
  logic          wrap;
  // outputs are computed from cnt_n so the registered values line up with cnt
  always_comb begin
    nd      = DW'(clamp_div(32'(new_div)));
    nh      = DW'(clamp_high(32'(new_high), 32'(nd)));
    np      = DW'(clamp_phase(32'(new_phase), 32'(nd)));
    wrap    = cnt >= div_r - 1'b1;
    apply   = pend && (wrap || resync);
    div_n   = apply ? nd : div_r;
    high_n  = apply ? nh : high_r;
    phase_n = apply ? np : phase_r;
    cnt_n   = resync ? phase_n : wrap ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      div_r   <= RST_DIV;
      high_r  <= RST_HIGH;
      phase_r <= '0;
      clk_out <= 1'b0;
      clk_en  <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      div_r   <= div_n;
      high_r  <= high_n;
      phase_r <= phase_n;
      clk_out <= cnt_n < high_n;
      clk_en  <= cnt_n == '0;
    end
endmodule

// File: rtl/clk_div_mgr.sv
// clk_div_mgr: multi-channel programmable clock divider with single config shadow and lock flag
module clk_div_mgr
  import clk_div_pkg::*;
#(
  parameter int  NCH      = 4,
  parameter int  DW       = 8,
  parameter int  DEF_DIV  = 4,
  parameter int  LOCK_CYC = 16,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clkin,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  input  logic [DW-1:0]  cfg_high,
  input  logic [DW-1:0]  cfg_phase,
  input  logic           resync,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] clk_en,
  output logic           lock
);
  localparam int LW = $clog2(LOCK_CYC + 1);
  lock_state_t    state;
  logic [LW-1:0]  lk_cnt;
  logic           pend, accept, evt;
  logic [CW-1:0]  sh_ch;
  logic [DW-1:0]  sh_div, sh_high, sh_phase;
  logic [NCH-1:0] applied;
  always_comb begin
    cfg_ready = (state != RST) && !pend;
    accept    = cfg_valid && cfg_ready;
    evt       = |applied || resync;
    lock      = state == LOCKED;
  end
  always_ff @(posedge clkin or posedge reset)
    if (reset) begin
      pend     <= 1'b0;
      sh_ch    <= '0;
      sh_div   <= '0;
      sh_high  <= '0;
      sh_phase <= '0;
    end else if (|applied) begin
      pend <= 1'b0;
    end else if (accept) begin
      pend     <= 1'b1;
      sh_ch    <= cfg_ch;
      sh_div   <= cfg_div;
      sh_high  <= cfg_high;
      sh_phase <= cfg_phase;
    end
  // an apply coinciding with resync is one event, so one restart
  always_ff @(posedge clkin or posedge reset)
    if (reset) begin
      state  <= RST;
      lk_cnt <= '0;
    end else if (state == RST || evt) begin
      state  <= SETTLE;
      lk_cnt <= '0;
    end else if (state == SETTLE) begin
      state  <= (lk_cnt == LW'(LOCK_CYC - 1)) ? LOCKED : SETTLE;
      lk_cnt <= lk_cnt + 1'b1;
    end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(
      .DW(DW),
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .clk(clkin),
      .rst(reset),
      .pend(pend && sh_ch == CW'(i)),
      .resync(resync),
      .new_div(sh_div),
      .new_high(sh_high),
      .new_phase(sh_phase),
      .apply(applied[i]),
      .clk_out(clk_out[i]),
      .clk_en(clk_en[i])
    );
  end
endmodule

// File: tb/tb_clk_div_mgr.sv
// tb_clk_div_mgr: directed checks of clk_div_mgr with hand-computed cycle-by-cycle expectations
module tb_clk_div_mgr;
  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       resync = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;
  logic       cfg_ready, lock;
  logic [3:0] clk_out, clk_en;
  int cyc = 0, total = 0, passed = 0;
  logic [3:0] t1_out [8] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF};
  logic [3:0] t1_en  [8] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF};
  logic [3:0] t2_out [6] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hD, 4'hF};
  logic [3:0] t2_en  [6] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'hD, 4'h2};
  logic       t3_alt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       t3_en5 [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] t4_out [4] = '{4'hD, 4'hD, 4'h6, 4'h6};
  logic [3:0] t4_en  [4] = '{4'hD, 4'h0, 4'h2, 4'h0};
  logic       t5_out [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       t5_en  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       t5b    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clkin = ~clkin;

  clk_div_mgr #(
    .NCH(4),
    .DW(8),
    .DEF_DIV(4),
    .LOCK_CYC(16)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_high(cfg_high),
    .cfg_phase(cfg_phase),
    .resync(resync),
    .clk_out(clk_out),
    .clk_en(clk_en),
    .lock(lock)
  );

  task automatic nxt();
    @(negedge clkin);
    cyc++;
  endtask

  task automatic to(input int n);
    while (cyc < n) nxt();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, want);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] h, input logic [7:0] p);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_high  = h;
    cfg_phase = p;
  endtask

  initial begin
    repeat (2) @(negedge clkin);
    chk("rst_out", clk_out, 4'h0);
    chk("rst_en", clk_en, 4'h0);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_lock", lock, 1'b0);
    reset = 1'b0;
    // defaults: period 4, high 2, ready at +1, lock at +17
    to(1);
    chk("t1_ready", cfg_ready, 1'b1);
    chk("t1_lock_lo", lock, 1'b0);
    for (int k = 0; k < 8; k++) begin
      to(1 + k);
      chk("t1_out", clk_out, t1_out[k]);
      chk("t1_en", clk_en, t1_en[k]);
    end
    to(16);
    chk("t1_lock16", lock, 1'b0);
    to(17);
    chk("t1_lock17", lock, 1'b1);
    // ch1 div=5 high=2 accepted while cnt=1, applied at the wrap ending cycle 19
    cfg(2'd1, 8'd5, 8'd2, 8'd0);
    to(18);
    cfg_valid = 1'b0;
    chk("t2_ready_busy", cfg_ready, 1'b0);
    to(19);
    chk("t2_ready_wrap", cfg_ready, 1'b0);
    chk("t2_lock_pre", lock, 1'b1);
    to(20);
    chk("t2_ready_back", cfg_ready, 1'b1);
    chk("t2_lock_drop", lock, 1'b0);
    for (int k = 0; k < 6; k++) begin
      to(20 + k);
      chk("t2_out", clk_out, t2_out[k]);
      chk("t2_en", clk_en, t2_en[k]);
    end
    to(35);
    chk("t2_lock35", lock, 1'b0);
    to(36);
    chk("t2_lock36", lock, 1'b1);
    // clamps on ch2: div=0 -> period 2
    cfg(2'd2, 8'd0, 8'd1, 8'd0);
    to(37);
    cfg_valid = 1'b0;
    chk("t3_ready_busy", cfg_ready, 1'b0);
    to(40);
    chk("t3_ready_back", cfg_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      to(40 + k);
      chk("t3_div0_out", clk_out[2], t3_alt[k]);
      chk("t3_div0_en", clk_en[2], t3_alt[k]);
    end
    // high=0 -> constant low, enables still every 5
    cfg(2'd2, 8'd5, 8'd0, 8'd0);
    to(44);
    cfg_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      to(46 + k);
      chk("t3_h0_out", clk_out[2], 1'b0);
      chk("t3_h0_en", clk_en[2], t3_en5[k]);
    end
    // high=9 with div=5 -> constant high; phase=7 stored as 0
    cfg(2'd2, 8'd5, 8'd9, 8'd7);
    to(52);
    cfg_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      to(56 + k);
      chk("t3_h9_out", clk_out[2], 1'b1);
      chk("t3_h9_en", clk_en[2], t3_en5[k]);
    end
    // ch1 div=4 high=2 phase=2, then resync
    cfg(2'd1, 8'd4, 8'd2, 8'd2);
    to(62);
    cfg_valid = 1'b0;
    to(65);
    chk("t4_ready", cfg_ready, 1'b1);
    resync = 1'b1;
    to(66);
    resync = 1'b0;
    chk("t4_lock", lock, 1'b0);
    for (int k = 0; k < 4; k++) begin
      to(66 + k);
      chk("t4_out", clk_out, t4_out[k]);
      chk("t4_en", clk_en, t4_en[k]);
    end
    // config for ch2 together with resync: accepted, applied at ch2 wrap ending cycle 74
    cfg(2'd2, 8'd6, 8'd3, 8'd0);
    resync = 1'b1;
    to(70);
    cfg_valid = 1'b0;
    resync = 1'b0;
    chk("t5_ready_busy", cfg_ready, 1'b0);
    chk("t5_rs_out", clk_out[2], 1'b1);
    chk("t5_rs_en", clk_en[2], 1'b1);
    to(74);
    chk("t5_ready_wait", cfg_ready, 1'b0);
    to(75);
    chk("t5_ready_back", cfg_ready, 1'b1);
    chk("t5_lock_apply", lock, 1'b0);
    for (int k = 0; k < 7; k++) begin
      to(75 + k);
      chk("t5_out", clk_out[2], t5_out[k]);
      chk("t5_en", clk_en[2], t5_en[k]);
    end
    to(86);
    chk("t5_lock86", lock, 1'b0);
    to(90);
    chk("t5_lock90", lock, 1'b0);
    to(91);
    chk("t5_lock91", lock, 1'b1);
    // pending ch0 config taken by resync before its wrap, cnt loads new phase
    cfg(2'd0, 8'd3, 8'd1, 8'd1);
    to(92);
    cfg_valid = 1'b0;
    chk("t5b_ready_busy", cfg_ready, 1'b0);
    chk("t5b_lock_hold", lock, 1'b1);
    resync = 1'b1;
    to(93);
    resync = 1'b0;
    chk("t5b_ready_back", cfg_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      to(93 + k);
      chk("t5b_out", clk_out[0], t5b[k]);
      chk("t5b_en", clk_en[0], t5b[k]);
    end
    to(108);
    chk("t5b_lock108", lock, 1'b0);
    to(109);
    chk("t5b_lock109", lock, 1'b1);
    // reset while ch3 config is pending
    cfg(2'd3, 8'd8, 8'd4, 8'd0);
    to(110);
    cfg_valid = 1'b0;
    chk("t6_ready_busy", cfg_ready, 1'b0);
    to(111);
    reset = 1'b1;
    #1;
    chk("t6_rst_out", clk_out, 4'h0);
    chk("t6_rst_en", clk_en, 4'h0);
    chk("t6_rst_ready", cfg_ready, 1'b0);
    chk("t6_rst_lock", lock, 1'b0);
    to(112);
    reset = 1'b0;
    to(113);
    chk("t6_ready", cfg_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      to(113 + k);
      chk("t6_out", clk_out, t1_out[k]);
      chk("t6_en", clk_en, t1_en[k]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
